// File: rtl/packet_header_deparser_if.sv
// Bundle of the PHV handshake, both AXI-Stream ports and the action-table write port.
// The slave modport is the deparser's view; master is the environment driving it.
interface packet_header_deparser_if #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int PKT_HDR_LEN          = 1124,
  parameter int NUM_ACTIONS          = 10
);
  logic [PKT_HDR_LEN-1:0]            phv_in;
  logic                              phv_valid;
  logic                              phv_ready;
  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser;
  logic                              s_axis_tvalid;
  logic                              s_axis_tlast;
  logic                              s_axis_tready;
  logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser;
  logic                              m_axis_tvalid;
  logic                              m_axis_tlast;
  logic                              m_axis_tready;
  logic                              act_wr_en;
  logic [3:0]                        act_wr_addr;
  logic [NUM_ACTIONS*16-1:0]         act_wr_data;
  logic [2:0]                        dbg_state;

  // Handshakes: a transfer happens on a rising clock edge where valid and ready
  // are both high; a source holds valid and its payload stable until that edge.
  modport slave (
    input  phv_in, phv_valid, s_axis_tdata, s_axis_tkeep, s_axis_tuser,
           s_axis_tvalid, s_axis_tlast, m_axis_tready,
           act_wr_en, act_wr_addr, act_wr_data,
    output phv_ready, s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tuser,
           m_axis_tvalid, m_axis_tlast, dbg_state
  );

  modport master (
    output phv_in, phv_valid, s_axis_tdata, s_axis_tkeep, s_axis_tuser,
           s_axis_tvalid, s_axis_tlast, m_axis_tready,
           act_wr_en, act_wr_addr, act_wr_data,
    input  phv_ready, s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tuser,
           m_axis_tvalid, m_axis_tlast, dbg_state
  );
endinterface

// File: rtl/packet_header_deparser.sv
// Egress deparser: buffers the first 128 bytes of a packet, overwrites them with PHV
// containers at offsets from a per-VLAN action table, then streams the packet out.
module packet_header_deparser #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int PKT_HDR_LEN          = 1124,
  parameter int NUM_HDR_SEGS         = 4,
  parameter int NUM_ACTIONS          = 10
) (
  input  logic axis_clk,
  input  logic aresetn,
  packet_header_deparser_if.slave bus
);
  localparam int DW        = C_S_AXIS_DATA_WIDTH;
  localparam int KW        = DW / 8;
  localparam int UW        = C_S_AXIS_TUSER_WIDTH;
  localparam int BUF_W     = NUM_HDR_SEGS * DW;
  localparam int BUF_BYTES = BUF_W / 8;
  localparam int IW        = $clog2(NUM_HDR_SEGS);
  localparam int ACT_W     = NUM_ACTIONS * 16;
  localparam int VLAN_LSB  = 120;
  localparam int C6_TOP    = PKT_HDR_LEN - 1;
  localparam int C4_TOP    = C6_TOP - 8 * 48;
  localparam int C2_TOP    = C4_TOP - 8 * 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_LOOKUP  = 3'd2,
    S_APPLY   = 3'd3,
    S_EMIT    = 3'd4,
    S_PASS    = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic                    ready_en_q;
  logic [PKT_HDR_LEN-1:0]  phv_q;
  logic [BUF_W-1:0]        buf_q, buf_apply;
  logic [KW-1:0]           keep_q [NUM_HDR_SEGS];
  logic [NUM_HDR_SEGS-1:0] last_q;
  logic [IW-1:0]           col_cnt_q, last_idx_q, emit_cnt_q;
  logic [ACT_W-1:0]        table_q [16];
  logic [ACT_W-1:0]        act_q;
  logic                    unused_bits;

  assign unused_bits   = ^bus.s_axis_tuser;
  assign bus.dbg_state = state_q;

  // Container bytes go little-endian from the offset; anything past the buffer end is dropped.
  function automatic logic [BUF_W-1:0] apply_action(input logic [BUF_W-1:0] b,
                                                    input logic [15:0] act,
                                                    input logic [PKT_HDR_LEN-1:0] phv);
    logic [47:0] cont;
    int len, idx, off;
    cont = '0;
    len  = 0;
    idx  = int'(act[3:1]);
    off  = int'(act[12:6]);
    case (act[5:4])
      2'd1: begin len = 2; cont[15:0] = phv[C2_TOP - 16 * idx -: 16]; end
      2'd2: begin len = 4; cont[31:0] = phv[C4_TOP - 32 * idx -: 32]; end
      2'd3: begin len = 6; cont      = phv[C6_TOP - 48 * idx -: 48]; end
      default: len = 0;
    endcase
    apply_action = b;
    if (act[0]) begin
      for (int k = 0; k < 6; k++) begin
        if (k < len && off + k < BUF_BYTES) apply_action[(off + k) * 8 +: 8] = cont[8 * k +: 8];
      end
    end
  endfunction

  always_comb begin
    buf_apply = buf_q;
    for (int a = 0; a < NUM_ACTIONS; a++) buf_apply = apply_action(buf_apply, act_q[16 * a +: 16], phv_q);
  end

  always_comb begin
    state_d           = state_q;
    bus.phv_ready     = 1'b0;
    bus.s_axis_tready = 1'b0;
    bus.m_axis_tdata  = '0;
    bus.m_axis_tkeep  = '0;
    bus.m_axis_tuser  = '0;
    bus.m_axis_tvalid = 1'b0;
    bus.m_axis_tlast  = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.phv_ready = ready_en_q;
        if (bus.phv_valid && ready_en_q) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        bus.s_axis_tready = 1'b1;
        if (bus.s_axis_tvalid && (bus.s_axis_tlast || col_cnt_q == IW'(NUM_HDR_SEGS - 1)))
          state_d = S_LOOKUP;
      end
      S_LOOKUP: state_d = S_APPLY;
      S_APPLY:  state_d = S_EMIT;
      S_EMIT: begin
        bus.m_axis_tvalid = 1'b1;
        bus.m_axis_tdata  = buf_q[int'(emit_cnt_q) * DW +: DW];
        bus.m_axis_tkeep  = keep_q[emit_cnt_q];
        bus.m_axis_tlast  = last_q[emit_cnt_q];
        if (emit_cnt_q == '0) bus.m_axis_tuser = phv_q[UW-1:0];
        if (bus.m_axis_tready && emit_cnt_q == last_idx_q)
          state_d = last_q[emit_cnt_q] ? S_IDLE : S_PASS;
      end
      S_PASS: begin
        bus.m_axis_tvalid = bus.s_axis_tvalid;
        bus.m_axis_tdata  = bus.s_axis_tdata;
        bus.m_axis_tkeep  = bus.s_axis_tkeep;
        bus.m_axis_tlast  = bus.s_axis_tlast;
        bus.s_axis_tready = bus.m_axis_tready;
        if (bus.s_axis_tvalid && bus.m_axis_tready && bus.s_axis_tlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // ready_en_q keeps phv_ready low while reset is held and releases it one clock later.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      ready_en_q <= 1'b0;
      phv_q      <= '0;
      buf_q      <= '0;
      last_q     <= '0;
      col_cnt_q  <= '0;
      last_idx_q <= '0;
      emit_cnt_q <= '0;
      act_q      <= '0;
      for (int s = 0; s < NUM_HDR_SEGS; s++) keep_q[s] <= '0;
    end else begin
      ready_en_q <= 1'b1;
      case (state_q)
        S_IDLE: if (bus.phv_valid && ready_en_q) begin
          phv_q      <= bus.phv_in;
          col_cnt_q  <= '0;
          emit_cnt_q <= '0;
        end
        S_COLLECT: if (bus.s_axis_tvalid) begin
          buf_q[int'(col_cnt_q) * DW +: DW] <= bus.s_axis_tdata;
          keep_q[col_cnt_q] <= bus.s_axis_tkeep;
          last_q[col_cnt_q] <= bus.s_axis_tlast;
          last_idx_q        <= col_cnt_q;
          col_cnt_q         <= col_cnt_q + IW'(1);
        end
        S_LOOKUP: act_q <= table_q[buf_q[VLAN_LSB +: 4]];
        S_APPLY:  buf_q <= buf_apply;
        S_EMIT:   if (bus.m_axis_tready) emit_cnt_q <= emit_cnt_q + IW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int e = 0; e < 16; e++) table_q[e] <= '0;
    end else if (bus.act_wr_en) begin
      table_q[bus.act_wr_addr] <= bus.act_wr_data;
    end
  end
endmodule

// File: tb/tb_packet_header_deparser.sv
// Self-checking bench for packet_header_deparser: randomized packets, PHVs and action
// tables checked against a byte-level reference model of the header rewrite.
module tb_packet_header_deparser;
  localparam int DW = 256;
  localparam int KW = 32;
  localparam int UW = 128;
  localparam int HW = 1124;
  localparam int BW = UW + 1 + KW + DW;

  logic axis_clk = 1'b0;
  logic aresetn  = 1'b0;
  always #5 axis_clk = ~axis_clk;

  packet_header_deparser_if #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW),
                              .PKT_HDR_LEN(HW), .NUM_ACTIONS(10)) bus ();

  packet_header_deparser #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW),
                           .PKT_HDR_LEN(HW), .NUM_HDR_SEGS(4), .NUM_ACTIONS(10))
    dut (.axis_clk(axis_clk), .aresetn(aresetn), .bus(bus));

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  always @(posedge axis_clk) cyc <= cyc + 1;

  logic [DW-1:0]  pkt_data [8];
  int             n_beats;
  logic [KW-1:0]  last_keep;
  logic [47:0]    c6 [8];
  logic [31:0]    c4 [8];
  logic [15:0]    c2 [8];
  logic [99:0]    cond_v;
  logic [UW-1:0]  tuser_v;
  logic [159:0]   tab [16];
  logic [BW-1:0]  exp_q [$];
  logic [BW-1:0]  got_q [$];
  int             hs_last_cyc, first_valid_cyc, stall_err, ready_mode;
  bit             send_to, recv_to, saw_pass;

  function automatic logic [15:0] make_act(int valid, int idx, int typ, int off);
    return 16'(valid | (idx << 1) | (typ << 4) | (off << 6));
  endfunction

  function automatic logic [HW-1:0] build_phv();
    logic [HW-1:0] p;
    int pos;
    p = '0;
    pos = HW;
    for (int i = 0; i < 8; i++) begin p[pos-1 -: 48] = c6[i]; pos -= 48; end
    for (int i = 0; i < 8; i++) begin p[pos-1 -: 32] = c4[i]; pos -= 32; end
    for (int i = 0; i < 8; i++) begin p[pos-1 -: 16] = c2[i]; pos -= 16; end
    p[pos-1 -: 100] = cond_v;
    p[UW-1:0] = tuser_v;
    return p;
  endfunction

  function automatic logic [BW-1:0] pack_beat(logic [UW-1:0] u, logic l, logic [KW-1:0] k, logic [DW-1:0] d);
    return {u, l, k, d};
  endfunction

  task automatic randomize_phv();
    for (int i = 0; i < 8; i++) begin
      c6[i] = 48'({$urandom, $urandom});
      c4[i] = $urandom;
      c2[i] = 16'($urandom);
    end
    cond_v  = 100'({$urandom, $urandom, $urandom, $urandom});
    tuser_v = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic randomize_packet(input int n, input int vlan, input logic [KW-1:0] lk);
    n_beats = n;
    last_keep = lk;
    for (int b = 0; b < 8; b++)
      for (int w = 0; w < 8; w++) pkt_data[b][32*w +: 32] = $urandom;
    pkt_data[0][123:120] = 4'(vlan);
  endtask

  task automatic write_entry(input logic [3:0] addr, input logic [159:0] data);
    @(posedge axis_clk); #1;
    bus.act_wr_en = 1'b1;
    bus.act_wr_addr = addr;
    bus.act_wr_data = data;
    @(posedge axis_clk); #1;
    bus.act_wr_en = 1'b0;
    tab[addr] = data;
  endtask

  // Reference model: edit a 128-byte image of the packet head, then list every output beat.
  task automatic build_expected();
    logic [7:0]  hb [128];
    logic [15:0] act;
    logic [47:0] val;
    logic [DW-1:0] d;
    int nseg, vlan, len, off, idx;
    exp_q.delete();
    nseg = (n_beats < 4) ? n_beats : 4;
    for (int b = 0; b < 128; b++) hb[b] = (b < nseg * 32) ? pkt_data[b / 32][8 * (b % 32) +: 8] : 8'h00;
    vlan = int'(hb[15][3:0]);
    for (int a = 0; a < 10; a++) begin
      act = tab[vlan][16*a +: 16];
      len = 2 * int'(act[5:4]);
      idx = int'(act[3:1]);
      off = int'(act[12:6]);
      val = (act[5:4] == 2'd1) ? {32'd0, c2[idx]} : (act[5:4] == 2'd2) ? {16'd0, c4[idx]} : c6[idx];
      if (act[0])
        for (int k = 0; k < len; k++) if (off + k < 128) hb[off + k] = val[8*k +: 8];
    end
    for (int s = 0; s < n_beats; s++) begin
      if (s < nseg) for (int j = 0; j < 32; j++) d[8*j +: 8] = hb[32 * s + j];
      else d = pkt_data[s];
      exp_q.push_back(pack_beat((s == 0) ? tuser_v : '0, s == n_beats - 1,
                                (s == n_beats - 1) ? last_keep : '1, d));
    end
  endtask

  task automatic send_packet();
    bit acc;
    int nseg;
    send_to = 0;
    nseg = (n_beats < 4) ? n_beats : 4;
    @(posedge axis_clk); #1;
    bus.phv_in = build_phv();
    bus.phv_valid = 1'b1;
    acc = 0;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge axis_clk); acc = bus.phv_ready;
      @(posedge axis_clk); #1;
    end
    bus.phv_valid = 1'b0;
    if (!acc) send_to = 1;
    for (int b = 0; b < n_beats && !send_to; b++) begin
      bus.s_axis_tdata  = pkt_data[b];
      bus.s_axis_tkeep  = (b == n_beats - 1) ? last_keep : '1;
      bus.s_axis_tlast  = (b == n_beats - 1);
      bus.s_axis_tvalid = 1'b1;
      acc = 0;
      for (int t = 0; t < 300 && !acc; t++) begin
        @(negedge axis_clk);
        acc = bus.s_axis_tready;
        if (acc && b == nseg - 1) hs_last_cyc = cyc;
        @(posedge axis_clk); #1;
      end
      if (!acc) send_to = 1;
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic recv_packet();
    logic [BW-1:0] cur, prev;
    bit done, prev_stall;
    int k;
    recv_to = 0; stall_err = 0; saw_pass = 0; first_valid_cyc = -1;
    got_q.delete();
    done = 0; prev_stall = 0; k = 0; prev = '0;
    bus.m_axis_tready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge axis_clk);
      if (bus.dbg_state == 3'd5) saw_pass = 1;
      cur = pack_beat(bus.m_axis_tuser, bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata);
      if (prev_stall && (!bus.m_axis_tvalid || cur !== prev)) stall_err++;
      if (bus.m_axis_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        got_q.push_back(cur);
        if (bus.m_axis_tlast) done = 1;
      end
      prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
      prev = cur;
      @(posedge axis_clk); #1;
      if (ready_mode == 1) bus.m_axis_tready = 1'($urandom_range(0, 1));
      else if (ready_mode == 2 && first_valid_cyc >= 0) begin
        k++;
        bus.m_axis_tready = (k % 4 == 0) || (k % 4 == 3);
      end
    end
    if (!done) recv_to = 1;
    bus.m_axis_tready = 1'b1;
  endtask

  task automatic run_packet(input int mode);
    ready_mode = mode;
    build_expected();
    fork
      send_packet();
      recv_packet();
    join
  endtask

  task automatic test_reset();
    repeat (3) @(posedge axis_clk);
    @(negedge axis_clk);
    tests_run++;
    if ({bus.phv_ready, bus.s_axis_tready, bus.m_axis_tvalid, bus.m_axis_tlast} !== 4'b0) begin
      tests_failed++; $display("FAIL reset_ctrl got %b exp 0000", {bus.phv_ready, bus.s_axis_tready, bus.m_axis_tvalid, bus.m_axis_tlast});
    end
    tests_run++;
    if ({bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tuser} !== '0) begin
      tests_failed++; $display("FAIL reset_data got %h exp 0", {bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tuser});
    end
    @(posedge axis_clk); #1 aresetn = 1'b1;
    @(posedge axis_clk); @(negedge axis_clk);
    tests_run++;
    if (bus.phv_ready !== 1'b1 || bus.dbg_state !== 3'd0) begin
      tests_failed++; $display("FAIL idle_ready got ready=%b state=%0d exp ready=1 state=0", bus.phv_ready, bus.dbg_state);
    end
  endtask

  task automatic test_single_action();
    write_entry(4'd2, {144'd0, make_act(1, 0, 3, 0)});
    randomize_phv();
    c6[0] = 48'h112233445566;
    randomize_packet(4, 2, '1);
    run_packet(0);
    tests_run++;
    if (send_to || recv_to || got_q.size() != 4) begin
      tests_failed++; $display("FAIL single_count got %0d beats (to=%0d/%0d) exp 4", got_q.size(), send_to, recv_to);
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL single_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
      end
      tests_run++;
      if (got_q[0][47:0] !== 48'h112233445566) begin
        tests_failed++; $display("FAIL single_bytes0_5 got %h exp 112233445566", got_q[0][47:0]);
      end
      tests_run++;
      if (first_valid_cyc !== hs_last_cyc + 3) begin
        tests_failed++; $display("FAIL single_latency got %0d exp %0d", first_valid_cyc - hs_last_cyc, 3);
      end
    end
  endtask

  task automatic test_short_packet();
    randomize_phv();
    randomize_packet(2, 2, 32'h0000FFFF);
    run_packet(0);
    tests_run++;
    if (send_to || recv_to || got_q.size() != 2) begin
      tests_failed++; $display("FAIL short_count got %0d beats exp 2", got_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        tests_run++;
        if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL short_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
      end
      tests_run++;
      if (got_q[1][DW +: KW + 1] !== {1'b1, 32'h0000FFFF}) begin
        tests_failed++; $display("FAIL short_keep_last got %h exp 10000ffff", got_q[1][DW +: KW + 1]);
      end
    end
    tests_run++;
    if (saw_pass) begin tests_failed++; $display("FAIL short_no_pass got pass=1 exp 0"); end
  endtask

  task automatic test_passthrough();
    write_entry(4'd7, {$urandom, $urandom, $urandom, $urandom, $urandom});
    randomize_phv();
    randomize_packet(7, 7, 32'h00FF00FF);
    run_packet(0);
    tests_run++;
    if (send_to || recv_to || got_q.size() != 7) begin
      tests_failed++; $display("FAIL pass_count got %0d beats exp 7", got_q.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        tests_run++;
        if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL pass_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
      end
      tests_run++;
      if (got_q[0][BW-1 -: UW] !== tuser_v || got_q[4][DW-1:0] !== pkt_data[4]) begin
        tests_failed++; $display("FAIL pass_tuser got %h exp %h", got_q[0][BW-1 -: UW], tuser_v);
      end
    end
  endtask

  task automatic test_overlap();
    write_entry(4'd5, {112'd0, make_act(1, 3, 2, 127), make_act(1, 1, 1, 10), make_act(1, 0, 1, 10)});
    randomize_phv();
    c2[0] = 16'hAAAA;
    c2[1] = 16'hBBBB;
    randomize_packet(4, 5, '1);
    run_packet(1);
    tests_run++;
    if (send_to || recv_to || got_q.size() != 4) begin
      tests_failed++; $display("FAIL overlap_count got %0d beats exp 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL overlap_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
      end
      tests_run++;
      if (got_q[0][95:80] !== 16'hBBBB) begin
        tests_failed++; $display("FAIL overlap_bytes10_11 got %h exp bbbb", got_q[0][95:80]);
      end
      tests_run++;
      if (got_q[3][255:240] !== {c4[3][7:0], pkt_data[3][247:240]}) begin
        tests_failed++; $display("FAIL clip_byte127 got %h exp %h", got_q[3][255:240], {c4[3][7:0], pkt_data[3][247:240]});
      end
    end
  endtask

  task automatic test_backpressure();
    write_entry(4'd9, {$urandom, $urandom, $urandom, $urandom, $urandom});
    randomize_phv();
    randomize_packet(6, 9, 32'h0000000F);
    run_packet(2);
    tests_run++;
    if (send_to || recv_to || got_q.size() != 6) begin
      tests_failed++; $display("FAIL bp_count got %0d beats exp 6", got_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests_run++;
        if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL bp_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
      end
    end
    tests_run++;
    if (stall_err != 0) begin tests_failed++; $display("FAIL bp_stable got %0d changes exp 0", stall_err); end
  endtask

  task automatic test_reset_mid_emit();
    bit in_emit;
    randomize_phv();
    randomize_packet(4, 2, '1);
    bus.m_axis_tready = 1'b0;
    send_packet();
    in_emit = 0;
    for (int t = 0; t < 20 && !in_emit; t++) begin
      @(negedge axis_clk);
      in_emit = (bus.dbg_state == 3'd4) && bus.m_axis_tvalid;
    end
    tests_run++;
    if (!in_emit || send_to) begin tests_failed++; $display("FAIL mid_reach_emit got %0d exp 1", in_emit); end
    #2 aresetn = 1'b0;
    #1;
    tests_run++;
    if ({bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tuser, bus.m_axis_tlast,
         bus.phv_ready, bus.s_axis_tready, bus.dbg_state} !== '0) begin
      tests_failed++; $display("FAIL mid_async_zero got valid=%b state=%0d data=%h exp 0", bus.m_axis_tvalid, bus.dbg_state, bus.m_axis_tdata);
    end
    @(posedge axis_clk); #1 aresetn = 1'b1;
    bus.m_axis_tready = 1'b1;
    for (int e = 0; e < 16; e++) tab[e] = '0;
    write_entry(4'd2, {128'd0, make_act(1, 2, 2, 20), make_act(1, 0, 3, 0)});
    randomize_phv();
    randomize_packet(5, 2, 32'h7FFFFFFF);
    run_packet(0);
    tests_run++;
    if (send_to || recv_to || got_q.size() != 5) begin
      tests_failed++; $display("FAIL post_reset_count got %0d beats exp 5", got_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL post_reset_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_random();
    for (int e = 0; e < 16; e++) write_entry(4'(e), {$urandom, $urandom, $urandom, $urandom, $urandom});
    for (int p = 0; p < 8; p++) begin
      randomize_phv();
      randomize_packet($urandom_range(1, 8), $urandom_range(0, 15), $urandom);
      run_packet(1);
      tests_run++;
      if (send_to || recv_to || got_q.size() != exp_q.size()) begin
        tests_failed++; $display("FAIL rand%0d_count got %0d beats exp %0d", p, got_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          tests_run++;
          if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL rand%0d_beat%0d got %h exp %h", p, i, got_q[i], exp_q[i]); end
        end
      end
      tests_run++;
      if (stall_err != 0) begin tests_failed++; $display("FAIL rand%0d_stable got %0d changes exp 0", p, stall_err); end
    end
  endtask

  initial begin
    bus.phv_in = '0;        bus.phv_valid = 1'b0;
    bus.s_axis_tdata = '0;  bus.s_axis_tkeep = '0;  bus.s_axis_tuser = '0;
    bus.s_axis_tvalid = 1'b0; bus.s_axis_tlast = 1'b0;
    bus.m_axis_tready = 1'b1;
    bus.act_wr_en = 1'b0;   bus.act_wr_addr = '0;   bus.act_wr_data = '0;
    for (int e = 0; e < 16; e++) tab[e] = '0;
    test_reset();
    test_single_action();
    test_short_packet();
    test_passthrough();
    test_overlap();
    test_backpressure();
    test_reset_mid_emit();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
